// File: rtl/axis_exp_adc_responder_pkg.sv
// Constants shared with the host-side ADC controller: device modes, register
// frame framing and the frame-tracking states of the responder.
package exp_adc_pkg;

   typedef enum logic {
      MODE_CONV = 1'b0,
      MODE_REG  = 1'b1
   } adc_mode_t;

   localparam logic [23:0] EXIT_WORD      = {1'b1, 15'h0014, 8'h01};
   localparam logic [2:0]  REG_HEADER     = 3'b101;
   localparam int          REG_FRAME_BITS = 24;

   typedef enum logic [1:0] {
      ST_DISARMED = 2'd0,
      ST_IDLE     = 2'd1,
      ST_CONV     = 2'd2,
      ST_REG      = 2'd3
   } frame_state_t;

endpackage

// File: rtl/axis_exp_adc_responder_if.sv
// AXI Stream channel. Handshake: a beat transfers on the rising aclk edge where
// tvalid and tready are both high; the master holds tdata stable while tvalid is high.
interface axis_exp_adc_responder_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_exp_adc_responder_spi_pin_sync.sv
// Two-flop synchroniser for one SPI pin, with single-cycle rise/fall pulses
// derived from the synchronised level.
module spi_pin_sync (
   input  logic aclk,
   input  logic areset,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);
   logic meta;
   logic sync;
   logic prev;

   // Clearing to 0 means a pin held low through reset shows no falling edge.
   always_ff @(posedge aclk) begin
      if (areset) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= pin;
         sync <= meta;
         prev <= sync;
      end
   end

   assign level = sync;
   assign rise  = sync & ~prev;
   assign fall  = ~sync & prev;
endmodule

// File: rtl/axis_exp_adc_responder.sv
// Device end of the experiment ADC SPI link: shifts buffered conversion samples
// out on NUM_SDO lanes and captures 24-bit register writes onto an AXI Stream.
module axis_exp_adc_responder
   import exp_adc_pkg::*;
#(
   parameter int NUM_SDO    = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic                 spi_csn,
   input  logic                 spi_sck,
   input  logic                 spi_sdi,
   output logic [NUM_SDO-1:0]   spi_sdo,
   axis_exp_adc_responder_if.slave  s_axis,
   axis_exp_adc_responder_if.master m_axis,
   output logic                 reg_mode,
   output logic                 underrun,
   output logic                 frame_err,
   output frame_state_t         dbg_state
);
   logic csn_lvl, csn_rise, csn_fall;
   logic sck_rise, sck_fall, sdi_lvl;
   logic unused_sck_lvl, unused_sdi_rise, unused_sdi_fall;

   spi_pin_sync u_sync_csn (
      .aclk(aclk), .areset(areset), .pin(spi_csn),
      .level(csn_lvl), .rise(csn_rise), .fall(csn_fall)
   );
   spi_pin_sync u_sync_sck (
      .aclk(aclk), .areset(areset), .pin(spi_sck),
      .level(unused_sck_lvl), .rise(sck_rise), .fall(sck_fall)
   );
   spi_pin_sync u_sync_sdi (
      .aclk(aclk), .areset(areset), .pin(spi_sdi),
      .level(sdi_lvl), .rise(unused_sdi_rise), .fall(unused_sdi_fall)
   );

   frame_state_t          state, state_next;
   adc_mode_t             mode;
   logic                  out_en;
   logic [DATA_WIDTH-1:0] buf_data, tx_sh, last_sample;
   logic                  buf_full;
   logic [23:0]           rx_sh, rx_next;
   logic [4:0]            bit_cnt, cnt_next;
   logic [31:0]           m_data;
   logic                  m_valid;
   logic                  frame_start, in_frame, conv_active, frame_close, m_empty;

   always_ff @(posedge aclk) begin
      if (areset) state <= ST_DISARMED;
      else        state <= state_next;
   end

   // DISARMED waits for CSn high so a frame running at reset release is skipped.
   always_comb begin
      state_next = state;
      case (state)
         ST_DISARMED: if (csn_lvl) state_next = ST_IDLE;
         ST_IDLE:     if (csn_fall) state_next = (mode == MODE_REG) ? ST_REG : ST_CONV;
         ST_CONV,
         ST_REG:      if (csn_rise) state_next = ST_IDLE;
         default:     state_next = ST_DISARMED;
      endcase
   end

   always_comb begin
      frame_start = 1'b0;
      in_frame    = 1'b0;
      conv_active = 1'b0;
      case (state)
         ST_IDLE: frame_start = csn_fall;
         ST_CONV: begin
            in_frame    = 1'b1;
            conv_active = 1'b1;
         end
         ST_REG:  in_frame = 1'b1;
         default: ;
      endcase
      spi_sdo = (conv_active && !csn_lvl) ? tx_sh[DATA_WIDTH-1 -: NUM_SDO] : '0;
   end

   assign frame_close = in_frame & csn_rise;
   assign m_empty     = ~m_valid | m_axis.tready;

   // A rising SCK in the closing cycle still lands before the frame is judged.
   always_comb begin
      rx_next  = rx_sh;
      cnt_next = bit_cnt;
      if (in_frame && sck_rise) begin
         rx_next = {rx_sh[22:0], sdi_lvl};
         if (bit_cnt != 5'd31) cnt_next = bit_cnt + 5'd1;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         mode        <= MODE_CONV;
         out_en      <= 1'b0;
         buf_data    <= '0;
         buf_full    <= 1'b0;
         tx_sh       <= '0;
         last_sample <= '0;
         rx_sh       <= '0;
         bit_cnt     <= '0;
         m_data      <= '0;
         m_valid     <= 1'b0;
         underrun    <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         out_en    <= 1'b1;
         underrun  <= 1'b0;
         frame_err <= 1'b0;

         if (s_axis.tvalid && s_axis.tready) begin
            buf_data <= s_axis.tdata;
            buf_full <= 1'b1;
         end
         if (m_axis.tvalid && m_axis.tready) m_valid <= 1'b0;

         if (frame_start) begin
            rx_sh   <= '0;
            bit_cnt <= '0;
            if (mode == MODE_CONV) begin
               if (buf_full) begin
                  tx_sh       <= buf_data;
                  last_sample <= buf_data;
                  buf_full    <= 1'b0;
               end else begin
                  tx_sh    <= last_sample;
                  underrun <= 1'b1;
               end
            end
         end else begin
            rx_sh   <= rx_next;
            bit_cnt <= cnt_next;
            if (conv_active && sck_fall && !csn_rise) tx_sh <= tx_sh << NUM_SDO;
         end

         if (frame_close) begin
            if (cnt_next == 5'(REG_FRAME_BITS)) begin
               if (m_empty) begin
                  m_data  <= {8'h00, rx_next};
                  m_valid <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
               end
               if (rx_next[23:21] == REG_HEADER)
                  mode <= MODE_REG;
               else if (mode == MODE_REG && rx_next == EXIT_WORD)
                  mode <= MODE_CONV;
            end else if (cnt_next != 5'd0 && mode == MODE_REG) begin
               frame_err <= 1'b1;
            end
         end
      end
   end

   assign s_axis.tready = out_en & ~buf_full;
   assign m_axis.tdata  = m_data;
   assign m_axis.tvalid = m_valid;
   assign reg_mode      = (mode == MODE_REG);
   assign dbg_state     = state;
endmodule

// File: tb/tb_axis_exp_adc_responder.sv
// Bench for axis_exp_adc_responder: conversion frames, a register frame table,
// m_axis backpressure and reset in the middle of a frame.
module tb_axis_exp_adc_responder;
   import exp_adc_pkg::*;

   localparam int HALF = 8;

   logic         aclk = 1'b0;
   logic         areset = 1'b1;
   logic         spi_csn = 1'b1;
   logic         spi_sck = 1'b0;
   logic         spi_sdi = 1'b0;
   logic [3:0]   spi_sdo;
   logic         reg_mode, underrun, frame_err;
   frame_state_t dbg_state;

   axis_exp_adc_responder_if #(.DATA_W(32)) s_axis ();
   axis_exp_adc_responder_if #(.DATA_W(32)) m_axis ();

   axis_exp_adc_responder #(.NUM_SDO(4), .DATA_WIDTH(32)) dut (
      .aclk(aclk), .areset(areset),
      .spi_csn(spi_csn), .spi_sck(spi_sck), .spi_sdi(spi_sdi), .spi_sdo(spi_sdo),
      .s_axis(s_axis), .m_axis(m_axis),
      .reg_mode(reg_mode), .underrun(underrun), .frame_err(frame_err),
      .dbg_state(dbg_state)
   );

   always #5 aclk = ~aclk;

   int errors = 0;
   int checks = 0;
   int und_cnt = 0;
   int err_cnt = 0;
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];

   // Output monitor: pulse counters and accepted m_axis words.
   always @(negedge aclk) begin
      if (!areset) begin
         if (underrun === 1'b1) und_cnt++;
         if (frame_err === 1'b1) err_cnt++;
         if (m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1) got_q.push_back(m_axis.tdata);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic drain(input string name);
      logic [31:0] g, e;
      while (got_q.size() > 0) begin
         g = got_q.pop_front();
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_extra: got word %h, required no word", name, g);
         end else begin
            e = exp_q.pop_front();
            check({name, "_word"}, g, e);
         end
      end
      check({name, "_pending"}, exp_q.size(), 0);
   endtask

   task automatic load_sample(input logic [31:0] d);
      int n = 0;
      while (s_axis.tready !== 1'b1 && n < 200) begin
         cycles(1);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL load_timeout: got tready %b, required 1", s_axis.tready);
      end
      s_axis.tdata  = d;
      s_axis.tvalid = 1'b1;
      cycles(1);
      s_axis.tvalid = 1'b0;
   endtask

   task automatic sck_bit(input logic b, output logic [3:0] lanes);
      spi_sdi = b;
      cycles(HALF);
      lanes   = spi_sdo;
      spi_sck = 1'b1;
      cycles(HALF);
      spi_sck = 1'b0;
   endtask

   task automatic spi_frame(input logic [23:0] w, input int nbits, output logic [3:0] lane_or);
      logic [3:0] l;
      lane_or = '0;
      spi_csn = 1'b0;
      cycles(HALF);
      for (int i = 0; i < nbits; i++) begin
         sck_bit(w[nbits-1-i], l);
         lane_or |= l;
      end
      cycles(HALF);
      spi_csn = 1'b1;
      cycles(HALF);
   endtask

   task automatic conv_frame(output logic [31:0] got, output logic [3:0] tail, output logic rdy);
      logic [3:0] l;
      got = '0;
      spi_csn = 1'b0;
      cycles(HALF);
      rdy = s_axis.tready;
      for (int i = 0; i < 8; i++) begin
         sck_bit(1'b0, l);
         got = {got[27:0], l};
      end
      cycles(HALF);
      tail    = spi_sdo;
      spi_csn = 1'b1;
      cycles(HALF);
   endtask

   typedef struct {
      logic [23:0] word;
      int          nbits;
      logic        push;
      logic        exp_mode;
      int          exp_err;
   } reg_vec_t;

   reg_vec_t vecs[10];

   initial begin
      logic [31:0] got;
      logic [3:0]  tail, lanes;
      logic        rdy, prev_mode;
      int          u0, e0;
      string       nm;

      vecs[0] = '{24'h123456, 24, 1'b1, 1'b0, 0};
      vecs[1] = '{24'hA01234, 24, 1'b1, 1'b1, 0};
      vecs[2] = '{24'h0A5A5A, 20, 1'b0, 1'b1, 1};
      vecs[3] = '{24'h801401, 24, 1'b1, 1'b0, 0};
      vecs[4] = '{24'h00ABCD, 16, 1'b0, 1'b0, 0};
      vecs[5] = '{24'h801401, 24, 1'b1, 1'b0, 0};
      vecs[6] = '{24'hBFFFFF, 24, 1'b1, 1'b1, 0};
      vecs[7] = '{24'h000000, 0,  1'b0, 1'b1, 0};
      vecs[8] = '{24'hC00001, 24, 1'b1, 1'b1, 0};
      vecs[9] = '{24'h801401, 24, 1'b1, 1'b0, 0};

      s_axis.tdata  = '0;
      s_axis.tvalid = 1'b0;
      m_axis.tready = 1'b1;

      // Clock/reset
      cycles(5);
      check("rst_sdo", spi_sdo, 0);
      check("rst_s_tready", s_axis.tready, 0);
      check("rst_m_tvalid", m_axis.tvalid, 0);
      check("rst_m_tdata", m_axis.tdata, 0);
      check("rst_reg_mode", reg_mode, 0);
      check("rst_pulses", {underrun, frame_err}, 0);
      areset = 1'b0;
      cycles(10);
      check("post_rst_tready", s_axis.tready, 1);

      // Conversion frame, then a second frame with no fresh sample
      load_sample(32'hDEADBEEF);
      cycles(1);
      check("buf_full_tready", s_axis.tready, 0);
      u0 = und_cnt;
      conv_frame(got, tail, rdy);
      check("conv1_lanes", got, 32'hDEADBEEF);
      check("conv1_tail", tail, 0);
      check("conv1_tready", rdy, 1);
      check("conv1_underrun", und_cnt - u0, 0);
      conv_frame(got, tail, rdy);
      check("conv2_resend", got, 32'hDEADBEEF);
      check("conv2_underrun", und_cnt - u0, 1);
      drain("conv");

      // Register frame table
      for (int i = 0; i < 10; i++) begin
         nm = $sformatf("vec%0d", i);
         if (s_axis.tready === 1'b1) load_sample(32'hF0F0F0F0);
         prev_mode = reg_mode;
         e0 = err_cnt;
         if (vecs[i].push) exp_q.push_back({8'h00, vecs[i].word});
         spi_frame(vecs[i].word, vecs[i].nbits, lanes);
         check({nm, "_mode"}, reg_mode, vecs[i].exp_mode);
         check({nm, "_frame_err"}, err_cnt - e0, vecs[i].exp_err);
         if (prev_mode) check({nm, "_reg_sdo"}, lanes, 0);
         drain(nm);
      end

      // Backpressure: second word is dropped while the first is held
      m_axis.tready = 1'b0;
      e0 = err_cnt;
      spi_frame(24'h111111, 24, lanes);
      spi_frame(24'h222222, 24, lanes);
      check("bp_tvalid", m_axis.tvalid, 1);
      check("bp_tdata", m_axis.tdata, 32'h00111111);
      check("bp_frame_err", err_cnt - e0, 1);
      check("bp_mode", reg_mode, 0);
      exp_q.push_back(32'h00111111);
      m_axis.tready = 1'b1;
      cycles(3);
      drain("bp");

      // Reset in the middle of a frame
      exp_q.push_back(32'h00A01234);
      spi_frame(24'hA01234, 24, lanes);
      drain("pre_rst");
      m_axis.tready = 1'b0;
      spi_frame(24'h123456, 24, lanes);
      check("pre_rst_tvalid", m_axis.tvalid, 1);
      check("pre_rst_mode", reg_mode, 1);
      spi_csn = 1'b0;
      cycles(HALF);
      for (int i = 0; i < 3; i++) sck_bit(1'b1, lanes);
      areset = 1'b1;
      cycles(3);
      check("mid_rst_tvalid", m_axis.tvalid, 0);
      check("mid_rst_mode", reg_mode, 0);
      check("mid_rst_sdo_tready", {spi_sdo, s_axis.tready}, 0);
      m_axis.tready = 1'b1;
      areset = 1'b0;
      cycles(2);
      e0 = err_cnt;
      begin
         logic [23:0] rest;
         rest = 24'hA05555;
         for (int i = 0; i < 24; i++) sck_bit(rest[23-i], lanes);
      end
      cycles(HALF);
      spi_csn = 1'b1;
      cycles(HALF);
      check("stale_tvalid", m_axis.tvalid, 0);
      check("stale_mode", reg_mode, 0);
      check("stale_frame_err", err_cnt - e0, 0);
      drain("stale");
      exp_q.push_back(32'h00A01234);
      spi_frame(24'hA01234, 24, lanes);
      check("after_rst_mode", reg_mode, 1);
      drain("after_rst");
      exp_q.push_back(32'h00801401);
      spi_frame(24'h801401, 24, lanes);
      check("after_rst_exit", reg_mode, 0);
      drain("after_rst_exit");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
